// File: rtl/n64_cmd_tx.sv
// rtl/n64_cmd_tx.sv - N64 joybus console command transmitter with receiver listen window.
// Optional N64_AUTO_POLL_EN adds a periodic internal 0x01 poll request.
module n64_cmd_tx #(
  parameter int CYC_PER_US = 4,
  parameter int LISTEN_US  = 160,
  parameter int POLL_US    = 16000
) (
  input  logic       clk_4M,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  output logic       dout,
  output logic       dout_oe,
  output logic       rx_enable,
  output logic       busy,
  output logic       cmd_done
);

  localparam int U          = (CYC_PER_US < 1) ? 1 : CYC_PER_US;
  localparam int BIT_CYC    = 4 * U;
  localparam int STOP_CYC   = 3 * U;
  localparam int LISTEN_CYC = LISTEN_US * U;
  localparam int PH_W       = $clog2(BIT_CYC);
  localparam int LS_W       = $clog2(LISTEN_CYC + 1);

  localparam logic [PH_W-1:0] PH_ONE       = PH_W'(1);
  localparam logic [PH_W-1:0] PH_U         = PH_W'(U);
  localparam logic [PH_W-1:0] PH_3U        = PH_W'(3 * U);
  localparam logic [PH_W-1:0] PH_BIT_LAST  = PH_W'(BIT_CYC - 1);
  localparam logic [PH_W-1:0] PH_STOP_LAST = PH_W'(STOP_CYC - 1);
  localparam logic [LS_W-1:0] LS_ONE       = LS_W'(1);
  localparam logic [LS_W-1:0] LS_DONE      = LS_W'(LISTEN_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_STOP, S_LISTEN} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [LS_W-1:0] listen_q, listen_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            dout_q, dout_d;
  logic            dout_oe_q, dout_oe_d;
  logic            rx_enable_q, rx_enable_d;
  logic            busy_q, busy_d;
  logic            cmd_done_q, cmd_done_d;
  logic            start_any;
  logic [7:0]      launch_cmd;

`ifdef N64_AUTO_POLL_EN
  localparam int POLL_CYC = POLL_US * U;
  localparam int PL_W     = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(POLL_CYC - 1);
  localparam logic [PL_W-1:0] PL_ONE  = PL_W'(1);

  logic [PL_W-1:0] poll_q, poll_d;
  logic            pend_q, pend_d;
  logic            poll_tick, auto_req;

  // A tick that lands while busy is remembered and fired on the first IDLE cycle.
  always_comb begin
    poll_tick  = (poll_q == PL_LAST);
    poll_d     = poll_tick ? '0 : poll_q + PL_ONE;
    auto_req   = poll_tick | pend_q;
    start_any  = start | auto_req;
    launch_cmd = start ? cmd : 8'h01;
    pend_d     = (state_q == S_IDLE) ? 1'b0 : auto_req;
  end
`else
  logic unused_poll;
  assign unused_poll = (POLL_US > 0);
  always_comb begin
    start_any  = start;
    launch_cmd = cmd;
  end
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    listen_d  = listen_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start_any) begin
          state_d   = S_SEND;
          phase_d   = '0;
          bit_idx_d = 3'd7;
          shreg_d   = launch_cmd;
        end
      end
      S_SEND: begin
        if (phase_q == PH_BIT_LAST) begin
          phase_d = '0;
          if (bit_idx_q == 3'd0) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
            shreg_d   = {shreg_q[6:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      S_STOP: begin
        if (phase_q == PH_STOP_LAST) begin
          state_d  = S_LISTEN;
          phase_d  = '0;
          listen_d = '0;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      S_LISTEN: begin
        if (listen_q == LS_DONE) begin
          state_d  = S_IDLE;
          listen_d = '0;
        end else begin
          listen_d = listen_q + LS_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    dout_d      = 1'b1;
    dout_oe_d   = 1'b0;
    rx_enable_d = 1'b0;
    busy_d      = 1'b0;
    cmd_done_d  = 1'b0;
    case (state_d)
      S_SEND: begin
        dout_oe_d = 1'b1;
        busy_d    = 1'b1;
        dout_d    = shreg_d[7] ? (phase_d >= PH_U) : (phase_d >= PH_3U);
      end
      S_STOP: begin
        dout_oe_d = 1'b1;
        busy_d    = 1'b1;
        dout_d    = (phase_d >= PH_U);
      end
      S_LISTEN: begin
        // The extra terminal count is the cmd_done cycle; start is still ignored there.
        if (listen_d == LS_DONE) begin
          cmd_done_d = 1'b1;
        end else begin
          rx_enable_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_4M) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      listen_q    <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      dout_q      <= 1'b1;
      dout_oe_q   <= 1'b0;
      rx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_done_q  <= 1'b0;
`ifdef N64_AUTO_POLL_EN
      poll_q      <= '0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      listen_q    <= listen_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      dout_oe_q   <= dout_oe_d;
      rx_enable_q <= rx_enable_d;
      busy_q      <= busy_d;
      cmd_done_q  <= cmd_done_d;
`ifdef N64_AUTO_POLL_EN
      poll_q      <= poll_d;
      pend_q      <= pend_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign dout_oe   = dout_oe_q;
  assign rx_enable = rx_enable_q;
  assign busy      = busy_q;
  assign cmd_done  = cmd_done_q;

endmodule

// File: tb/tb_n64_cmd_tx.sv
// tb/tb_n64_cmd_tx.sv - randomized self-checking bench for n64_cmd_tx against a waveform model.
`timescale 1ns/1ps
module tb_n64_cmd_tx;
  localparam int U         = 4;
  localparam int LISTEN_US = 160;
  localparam logic [4:0] IDLE_OBS = 5'b10000;

  logic       clk_4M = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cmd;
  logic       dout, dout_oe, rx_enable, busy, cmd_done;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #125 clk_4M = ~clk_4M;

  n64_cmd_tx #(.CYC_PER_US(U), .LISTEN_US(LISTEN_US), .POLL_US(16000)) dut (
    .clk_4M(clk_4M), .reset(reset), .start(start), .cmd(cmd),
    .dout(dout), .dout_oe(dout_oe), .rx_enable(rx_enable), .busy(busy), .cmd_done(cmd_done)
  );

  function automatic logic [4:0] obs();
    return {dout, dout_oe, rx_enable, busy, cmd_done};
  endfunction

  // Expected per-cycle {dout, dout_oe, rx_enable, busy, cmd_done} starting the cycle after start is taken.
  task automatic build_model(input logic [7:0] b);
    int lo;
    exp_q.delete();
    for (int k = 7; k >= 0; k--) begin
      lo = b[k] ? U : 3 * U;
      repeat (lo) exp_q.push_back(5'b01010);
      repeat (4 * U - lo) exp_q.push_back(5'b11010);
    end
    repeat (U) exp_q.push_back(5'b01010);
    repeat (2 * U) exp_q.push_back(5'b11010);
    repeat (LISTEN_US * U) exp_q.push_back(5'b10110);
    exp_q.push_back(5'b10001);
  endtask

  task automatic launch(input logic [7:0] b, input string tag);
    @(negedge clk_4M);
    checks++;
    if (obs() !== IDLE_OBS) begin
      errors++;
      $display("FAIL %s_pre_idle got %b expected %b", tag, obs(), IDLE_OBS);
    end
    start = 1'b1;
    cmd   = b;
    @(negedge clk_4M);
  endtask

  // mode 0: quiet inputs, 1: random start/cmd noise, 2: cmd changed to 0x03 at cycle 20
  task automatic check_frame(input logic [7:0] b, input string tag, input int mode,
                             input bit chain, input logic [7:0] chain_b);
    int bad;
    int n;
    logic [4:0] got_bad, exp_bad;
    bad = -1;
    got_bad = '0;
    exp_bad = '0;
    build_model(b);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs() !== exp_q[i] && bad < 0) begin
        bad = i; got_bad = obs(); exp_bad = exp_q[i];
      end
      case (mode)
        1: begin start = 1'($urandom_range(0, 1)); cmd = 8'($urandom); end
        2: begin start = 1'b0; if (i == 20) cmd = 8'h03; end
        default: start = 1'b0;
      endcase
      if (chain && i == n - 1) begin
        start = 1'b1;
        cmd   = chain_b;
      end
      @(negedge clk_4M);
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_wave cycle %0d got %b expected %b", tag, bad, got_bad, exp_bad);
    end
    checks++;
    if (obs() !== IDLE_OBS) begin
      errors++;
      $display("FAIL %s_after_done got %b expected %b", tag, obs(), IDLE_OBS);
    end
    if (chain) begin
      @(negedge clk_4M);
    end else begin
      start = 1'b0;
      bad = -1;
      for (int t = 0; t < 4; t++) begin
        @(negedge clk_4M);
        if (obs() !== IDLE_OBS && bad < 0) begin bad = t; got_bad = obs(); end
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_idle_tail cycle %0d got %b expected %b", tag, bad, got_bad, IDLE_OBS);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cmd = 8'h00;
    repeat (3) @(negedge clk_4M);
    checks++;
    if (obs() !== IDLE_OBS) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", obs(), IDLE_OBS);
    end
    reset = 1'b0;
    @(negedge clk_4M);
    checks++;
    if (obs() !== IDLE_OBS) begin
      errors++;
      $display("FAIL post_reset_idle got %b expected %b", obs(), IDLE_OBS);
    end
  endtask

  task automatic test_read_cmd();
    launch(8'h01, "cmd01");
    check_frame(8'h01, "cmd01", 0, 1'b0, 8'h00);
  endtask

  task automatic test_patterns();
    logic [7:0] b;
    launch(8'hFF, "cmdFF");
    check_frame(8'hFF, "cmdFF", 0, 1'b0, 8'h00);
    launch(8'h00, "cmd00");
    check_frame(8'h00, "cmd00", 0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      launch(b, "rand");
      check_frame(b, "rand", 0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] b;
    for (int r = 0; r < 2; r++) begin
      b = 8'($urandom);
      launch(b, "noise");
      check_frame(b, "noise", 1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_cmd_change();
    launch(8'h01, "cmdchg");
    check_frame(8'h01, "cmdchg", 2, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    launch(b1, "b2b_first");
    check_frame(b1, "b2b_first", 0, 1'b1, b2);
    check_frame(b2, "b2b_second", 0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_midframe();
    int bad;
    logic [4:0] got_bad;
    logic [7:0] b;
    bad = -1;
    got_bad = '0;
    launch(8'hA5, "midrst");
    start = 1'b0;
    repeat (50) @(negedge clk_4M);
    reset = 1'b1;
    @(negedge clk_4M);
    checks++;
    if (obs() !== IDLE_OBS) begin
      errors++;
      $display("FAIL midrst_release got %b expected %b", obs(), IDLE_OBS);
    end
    reset = 1'b0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk_4M);
      if (obs() !== IDLE_OBS && bad < 0) begin bad = t; got_bad = obs(); end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL midrst_no_done cycle %0d got %b expected %b", bad, got_bad, IDLE_OBS);
    end
    b = 8'($urandom);
    launch(b, "midrst_after");
    check_frame(b, "midrst_after", 0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd   = 8'h00;
    test_reset();
    test_read_cmd();
    test_patterns();
    test_start_ignored();
    test_cmd_change();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n64_cmd_tx.md
Name: n64_cmd_tx

Overview:
- Console-side transmitter for the N64 joybus single-wire protocol.
- Serialises an 8-bit command (0x01 = read controller state), MSB first, followed by the console stop bit.
- Then releases the line and opens a listen window that drives the enable input of the controller-state receiver.
- Sits between the poll scheduler and the open-drain data pad, sharing clk_4M with the receiver.

Parameters:
- CYC_PER_US, 4, clk_4M cycles per microsecond; minimum 1.
- LISTEN_US, 160, listen window length in µs after the stop bit; covers a 33-bit response of 132 µs plus margin.
- POLL_US, 16000, auto-poll period in µs; used only with N64_AUTO_POLL_EN.

Ports:
- clk_4M  input  1  system clock, 4 MHz nominal.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send cmd; sampled only in IDLE.
- cmd  input  8  command byte; captured on the accepted start.
- dout  output  1  line level request: 0 = drive low, 1 = release.
- dout_oe  output  1  pad output enable; high only while in SEND or STOP.
- rx_enable  output  1  high for the whole listen window; connects to the receiver enable.
- busy  output  1  high in every state except IDLE.
- cmd_done  output  1  one-cycle pulse when the listen window ends.

Behaviour:
- All outputs are registered.
- Reset (sampled on the clk_4M edge) forces: state IDLE, dout=1, dout_oe=0, rx_enable=0, busy=0, cmd_done=0, all counters 0.
- Reset has the same effect mid-frame. The line is released on the next edge and no cmd_done is produced.
- Timing units: U = CYC_PER_US cycles. Bit time = 4U.
- Data bit 0: dout low for 3U, then high for 1U.
- Data bit 1: dout low for 1U, then high for 3U.
- Stop bit: dout low for 1U, then high for 2U.
- States:
  - IDLE: when start=1, latch cmd into the shift register and go to SEND with bit index 7. The first low dout appears on the following edge, so latency from start to line low is 1 cycle. busy asserts on the same edge.
  - SEND: a phase counter runs 0..4U-1. dout = 0 while phase < (bit ? U : 3U), else 1. At phase 4U-1: if the bit index is 0, go to STOP; otherwise decrement the index and shift left.
  - STOP: the phase counter runs 0..3U-1, with dout low for phase < U. At the last phase, go to LISTEN and drop dout_oe on that edge.
  - LISTEN: dout=1, dout_oe=0, rx_enable=1 for exactly LISTEN_US*U cycles. On the final cycle, rx_enable falls, cmd_done pulses for 1 cycle, and the state returns to IDLE.
- start while busy is ignored, not queued. A change on cmd while busy has no effect.
- start asserted on the same cycle as cmd_done is ignored, because the state is not yet IDLE. It is accepted on the next cycle if it is held.
- Total on-wire transmit length = 32U + 3U = 35U cycles, which is 140 at U=4.
- Counter widths are sized with $clog2 from the parameters. There is no overflow or wrap within a frame.

Optional Feature:
- Macro N64_AUTO_POLL_EN.
- Defined:
  - A free-running counter generates an internal start every POLL_US*U cycles, OR'd with the external start.
  - An auto-generated start always sends 0x01, ignoring cmd.
  - An external start accepted in IDLE uses cmd.
  - If an auto tick arrives while busy, it is held pending and fires on the first IDLE cycle.
  - Reset clears the poll counter and the pending flag.
- Undefined: only the external start launches frames. No poll counter logic is synthesised.

Test Plan:
- Reset released, start with cmd=0x01, U=4 -> dout sequence:
  - 7× (12 low, 4 high), then 4 low, 12 high, then stop 4 low, 8 high; 140 cycles in total.
  - dout_oe high for exactly those 140 cycles.
  - rx_enable high for 640 cycles, then a single cmd_done pulse; busy high for 780 cycles.
- start cmd=0xFF -> each bit is 4 low/12 high; cmd=0x00 -> each bit is 12 low/4 high; the first low appears 1 cycle after start.
- start pulsed repeatedly during SEND and LISTEN -> no change to the waveform; exactly one cmd_done. A start on the cmd_done cycle is ignored; a start 1 cycle later launches a new frame.
- reset asserted at cycle 50 of SEND -> the next edge gives dout=1, dout_oe=0, busy=0, no cmd_done; a later start sends a clean full frame.
- cmd changed from 0x01 to 0x03 at cycle 20 of a frame -> the transmitted byte remains 0x01.
- With N64_AUTO_POLL_EN, POLL_US=300, U=4 -> frames of 0x01 start every 1200 cycles. An auto tick during an external frame is deferred to the first IDLE cycle.
